// File: rtl/fence_sequencer.sv
// fence_sequencer: orders the store-buffer drain and the D$, I$, TLB and
// pipeline flushes that fence-class instructions need at commit, and
// returns a single-cycle done pulse so commit can retire the instruction.
module fence_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fence_req_i,
  input  logic fence_i_req_i,
  input  logic sfence_vma_req_i,
  input  logic amo_flush_req_i,
  input  logic no_st_pending_i,
  output logic flush_dcache_o,
  input  logic flush_dcache_ack_i,
  output logic flush_icache_o,
  input  logic flush_icache_ack_i,
  output logic flush_tlb_o,
  output logic flush_pipeline_o,
  output logic done_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAIN  = 3'd1;
  localparam logic [2:0] DFLUSH = 3'd2;
  localparam logic [2:0] IFLUSH = 3'd3;
  localparam logic [2:0] TLB    = 3'd4;
  localparam logic [2:0] PFLUSH = 3'd5;

  // A zero timeout still needs a one-bit counter so the logic elaborates.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [2:0]    state_q, state_d;
  logic          need_d_q, need_i_q, need_tlb_q;
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
  logic          cnt_last;
  logic          tmo_fire;
  logic          any_req;
  logic          waiting;

  assign any_req  = fence_req_i | fence_i_req_i | sfence_vma_req_i | amo_flush_req_i;
  assign cnt_last = TMO_EN && (cnt_q == CNT_LAST);
  assign waiting  = (state_q == DRAIN) || (state_q == DFLUSH) || (state_q == IFLUSH);

  // Next-state decode; a timeout takes the same exit as the real condition.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d  = state_q;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          // Flags are not latched yet, so decide from the live requests.
          state_d = (fence_req_i | fence_i_req_i | sfence_vma_req_i) ? DRAIN : PFLUSH;
        end
      end
      DRAIN: begin
        if (no_st_pending_i || cnt_last) begin
          state_d  = need_d_q ? DFLUSH : TLB;
          tmo_fire = !no_st_pending_i;
        end
      end
      DFLUSH: begin
        if (flush_dcache_ack_i || cnt_last) begin
          state_d  = need_i_q ? IFLUSH : (need_tlb_q ? TLB : PFLUSH);
          tmo_fire = !flush_dcache_ack_i;
        end
      end
      IFLUSH: begin
        if (flush_icache_ack_i || cnt_last) begin
          state_d  = need_tlb_q ? TLB : PFLUSH;
          tmo_fire = !flush_icache_ack_i;
        end
      end
      TLB:     state_d = PFLUSH;
      PFLUSH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, sticky timeout flag and per-state wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      timeout_q <= timeout_q | tmo_fire;
      if (state_d != state_q || !waiting) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Work flags: captured once in IDLE, held for the sequence, cleared after PFLUSH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      need_d_q   <= 1'b0;
      need_i_q   <= 1'b0;
      need_tlb_q <= 1'b0;
    end else if (state_q == IDLE && any_req) begin
      need_d_q   <= fence_req_i | fence_i_req_i;
      need_i_q   <= fence_i_req_i;
      need_tlb_q <= sfence_vma_req_i;
    end else if (state_q == PFLUSH) begin
      need_d_q   <= 1'b0;
      need_i_q   <= 1'b0;
      need_tlb_q <= 1'b0;
    end
  end

  // Outputs decode the state register only, so reset drops them at once.
  assign flush_dcache_o   = (state_q == DFLUSH);
  assign flush_icache_o   = (state_q == IFLUSH);
  assign flush_tlb_o      = (state_q == TLB);
  assign flush_pipeline_o = (state_q == PFLUSH);
  assign done_o           = (state_q == PFLUSH);
  assign busy_o           = (state_q != IDLE);
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_fence_sequencer.sv
// Directed bench for fence_sequencer: each cycle pushes the expected output
// vector to a scoreboard, and the vector is popped and compared mid-cycle.
module tb_fence_sequencer;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic fence_req_i, fence_i_req_i, sfence_vma_req_i, amo_flush_req_i;
  logic no_st_pending_i, flush_dcache_ack_i, flush_icache_ack_i;
  logic flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipeline_o;
  logic done_o, busy_o, timeout_o;

  int checks = 0;
  int errors = 0;

  // Output vector: {dcache, icache, tlb, pipeline, done, busy, timeout}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_BUSY = 7'b0000010;
  localparam logic [6:0] O_D    = 7'b1000010;
  localparam logic [6:0] O_I    = 7'b0100010;
  localparam logic [6:0] O_T    = 7'b0010010;
  localparam logic [6:0] O_P    = 7'b0001110;
  localparam logic [6:0] O_TMO  = 7'b0000001;

  // Request vector: {fence, fence_i, sfence_vma, amo}
  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_F    = 4'b1000;
  localparam logic [3:0] R_FI   = 4'b0100;
  localparam logic [3:0] R_SF   = 4'b0010;
  localparam logic [3:0] R_AMO  = 4'b0001;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];

  fence_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .fence_req_i        (fence_req_i),
    .fence_i_req_i      (fence_i_req_i),
    .sfence_vma_req_i   (sfence_vma_req_i),
    .amo_flush_req_i    (amo_flush_req_i),
    .no_st_pending_i    (no_st_pending_i),
    .flush_dcache_o     (flush_dcache_o),
    .flush_dcache_ack_i (flush_dcache_ack_i),
    .flush_icache_o     (flush_icache_o),
    .flush_icache_ack_i (flush_icache_ack_i),
    .flush_tlb_o        (flush_tlb_o),
    .flush_pipeline_o   (flush_pipeline_o),
    .done_o             (done_o),
    .busy_o             (busy_o),
    .timeout_o          (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic check();
    exp_t       e;
    logic [6:0] obs;
    obs = {flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipeline_o,
           done_o, busy_o, timeout_o};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
  endtask

  // One cycle: drive inputs, queue the expected outputs, check mid-cycle.
  task automatic cyc(input string tag, input logic [3:0] req, input logic nsp,
                     input logic dack, input logic iack, input logic [6:0] ev);
    exp_t e;
    {fence_req_i, fence_i_req_i, sfence_vma_req_i, amo_flush_req_i} = req;
    no_st_pending_i    = nsp;
    flush_dcache_ack_i = dack;
    flush_icache_ack_i = iack;
    e.tag = tag;
    e.v   = ev;
    sb.push_back(e);
    @(negedge clk_i);
    check();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    exp_t e;
    rst_ni = 1'b0;
    {fence_req_i, fence_i_req_i, sfence_vma_req_i, amo_flush_req_i} = R_NONE;
    no_st_pending_i = 1'b1; flush_dcache_ack_i = 1'b0; flush_icache_ack_i = 1'b0;
    #3;
    e.tag = "reset"; e.v = O_IDLE; sb.push_back(e);
    check();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // FENCE, D$ ack two cycles late; a late SFENCE.VMA while busy is ignored.
    cyc("fence_c0", R_F,         1, 0, 0, O_IDLE);
    cyc("fence_c1", R_F,         1, 0, 1, O_BUSY);
    cyc("fence_c2", R_F | R_SF,  1, 0, 1, O_D);
    cyc("fence_c3", R_F | R_SF,  1, 0, 0, O_D);
    cyc("fence_c4", R_F,         1, 1, 0, O_D);
    cyc("fence_c5", R_F,         1, 0, 0, O_P);
    cyc("fence_c6", R_NONE,      1, 0, 0, O_IDLE);

    // FENCE.I with the store buffer draining until cycle 4.
    cyc("fencei_c0", R_FI, 0, 0, 0, O_IDLE);
    cyc("fencei_c1", R_FI, 0, 1, 1, O_BUSY);
    cyc("fencei_c2", R_FI, 0, 1, 1, O_BUSY);
    cyc("fencei_c3", R_FI, 0, 1, 1, O_BUSY);
    cyc("fencei_c4", R_FI, 1, 1, 1, O_BUSY);
    cyc("fencei_c5", R_FI, 1, 1, 0, O_D);
    cyc("fencei_c6", R_FI, 1, 0, 1, O_I);
    cyc("fencei_c7", R_FI, 1, 0, 0, O_P);
    cyc("fencei_c8", R_NONE, 1, 0, 0, O_IDLE);

    // FENCE.I and SFENCE.VMA together, zero waits.
    cyc("combo_c0", R_FI | R_SF, 1, 0, 0, O_IDLE);
    cyc("combo_c1", R_FI | R_SF, 1, 0, 0, O_BUSY);
    cyc("combo_c2", R_FI | R_SF, 1, 1, 0, O_D);
    cyc("combo_c3", R_FI | R_SF, 1, 0, 1, O_I);
    cyc("combo_c4", R_FI | R_SF, 1, 0, 0, O_T);
    cyc("combo_c5", R_FI | R_SF, 1, 0, 0, O_P);
    cyc("combo_c6", R_NONE,      1, 0, 0, O_IDLE);

    // SFENCE.VMA alone: DRAIN, TLB, PFLUSH.
    cyc("sfence_c0", R_SF, 1, 0, 0, O_IDLE);
    cyc("sfence_c1", R_SF, 1, 0, 0, O_BUSY);
    cyc("sfence_c2", R_SF, 1, 0, 0, O_T);
    cyc("sfence_c3", R_SF, 1, 0, 0, O_P);
    cyc("sfence_c4", R_NONE, 1, 0, 0, O_IDLE);

    // AMO only, with stray acks that must be ignored.
    cyc("amo_c0", R_AMO, 1, 1, 1, O_IDLE);
    cyc("amo_c1", R_AMO, 1, 1, 1, O_P);
    cyc("amo_c2", R_NONE, 1, 0, 0, O_IDLE);

    // Reset asserted during DFLUSH drops everything asynchronously.
    cyc("rst_c0", R_F, 1, 0, 0, O_IDLE);
    cyc("rst_c1", R_F, 1, 0, 0, O_BUSY);
    cyc("rst_c2", R_F, 1, 0, 0, O_D);
    #2;
    rst_ni = 1'b0;
    #1;
    e.tag = "rst_async"; e.v = O_IDLE; sb.push_back(e);
    check();
    {fence_req_i, fence_i_req_i, sfence_vma_req_i, amo_flush_req_i} = R_NONE;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc("rst_amo_c0", R_AMO, 1, 0, 0, O_IDLE);
    cyc("rst_amo_c1", R_AMO, 1, 0, 0, O_P);
    cyc("rst_amo_c2", R_NONE, 1, 0, 0, O_IDLE);

    // TIMEOUT_CYCLES=8: D$ ack stuck low, forced exit after 8 DFLUSH cycles.
    cyc("tmo_c0", R_F, 1, 0, 0, O_IDLE);
    cyc("tmo_c1", R_F, 1, 0, 0, O_BUSY);
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("tmo_dflush%0d", i), R_F, 1, 0, 0, O_D);
    end
    cyc("tmo_done",   R_F,    1, 0, 0, O_P | O_TMO);
    cyc("tmo_sticky", R_NONE, 1, 0, 0, O_IDLE | O_TMO);
    cyc("tmo_amo_c0", R_AMO,  1, 0, 0, O_IDLE | O_TMO);
    cyc("tmo_amo_c1", R_AMO,  1, 0, 0, O_P | O_TMO);
    cyc("tmo_amo_c2", R_NONE, 1, 0, 0, O_IDLE | O_TMO);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
